// File: rtl/instr_loader_if.sv
// -----------------------------------------------------------------------------
// instr_loader_if
//
// Host-side word stream into the instruction loader.
//
// Signals:
//   in_word   [31:0]  instruction word offered by the host
//   in_valid          in_word is valid this cycle
//   in_last           marks the offered word as the final program word
//   in_ready          loader accepts a word on this clock edge
//
// Modports:
//   master  - host/program source (drives word/valid/last, sees ready)
//   slave   - instr_loader (sees word/valid/last, drives ready)
// -----------------------------------------------------------------------------
interface instr_loader_if;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;

    modport master (
        output in_word,
        output in_valid,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_word,
        input  in_valid,
        input  in_last,
        output in_ready
    );
endinterface

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Buffers 32-bit instruction words from the host in a small FIFO and plays
// them into the CPU instruction memory as one-cycle mem_write pulses, each
// followed by GAP_CYCLES idle cycles. Once the word flagged in_last has been
// written, a one-cycle start + cpu_rst launch pulse is issued and the loader
// parks in DONE until restart.
//
// Parameters:
//   DEPTH       FIFO depth in words (power of 2, >= 2)
//   GAP_CYCLES  idle cycles after each mem_write pulse (>= 1)
//   CNT_W       width of words_sent
//
// Ports:
//   clk               system clock, rising edge
//   rst               asynchronous active-high reset
//   host              instr_loader_if.slave (in_word/in_valid/in_last/in_ready)
//   restart           one-cycle pulse, re-arms the loader from DONE only
//   next_instruction  word presented to the CPU instruction memory
//   mem_write         one-cycle write strobe to the CPU
//   start             one-cycle CPU launch
//   cpu_rst           one-cycle CPU reset, coincident with start
//   busy              high in WRITE, GAP and LAUNCH
//   words_sent        mem_write pulses since reset/restart, saturating
//   checksum          running XOR of written words (see below)
//
// Build option:
//   INSTR_LOADER_CHECKSUM_EN  when defined, checksum accumulates the XOR of
//                             every word written; otherwise it is tied to 0.
// -----------------------------------------------------------------------------
module instr_loader #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    instr_loader_if.slave    host,
    input  logic             restart,
    output logic [31:0]      next_instruction,
    output logic             mem_write,
    output logic             start,
    output logic             cpu_rst,
    output logic             busy,
    output logic [CNT_W-1:0] words_sent,
    output logic [31:0]      checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [GW-1:0]    GAP_LOAD  = GW'(GAP_CYCLES);
    localparam logic [GW-1:0]    GAP_ONE   = GW'(1);
    localparam logic [AW:0]      PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ALL1  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_GAP    = 3'd2,
        S_LAUNCH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;

    logic [31:0]      mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic [31:0]      head_word_s;

    logic             last_seen_q, last_seen_d;
    logic [CNT_W-1:0] words_sent_q, words_sent_d;
    logic [31:0]      next_instr_q, next_instr_d;

    logic             mem_write_q;
    logic             start_q;
    logic             cpu_rst_q;
    logic             busy_q;

    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             clr_s;

    // ------------------------------------------------------------------
    // FIFO status and input handshake
    // ------------------------------------------------------------------
    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign count_s      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty_s = (count_s == {(AW+1){1'b0}});
    assign fifo_full_s  = (count_s == FULL_CNT);
    assign head_word_s  = mem_q[rd_ptr_q[AW-1:0]];

    // Ready depends only on registered state (plus rst, so the host sees
    // in_ready low for the whole reset). Once the last word is in, input is
    // refused until restart re-arms the loader.
    assign in_ready_s = !rst && !fifo_full_s && !last_seen_q &&
                        (state_q != S_LAUNCH) && (state_q != S_DONE);
    assign host.in_ready = in_ready_s;
    assign push_s        = host.in_valid && in_ready_s;

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    // Next state, gap counter, FIFO pop and restart-clear decisions
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        pop_s   = 1'b0;
        clr_s   = 1'b0;

        case (state_q)
            // IDLE and the final GAP cycle share the same dispatch rules, so
            // the next word follows its predecessor's gap with no dead cycle.
            S_IDLE, S_GAP: begin
                if ((state_q == S_GAP) && (gap_q > GAP_ONE)) begin
                    gap_d   = gap_q - GAP_ONE;
                    state_d = S_GAP;
                end else if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    state_d = S_WRITE;
                end else if (last_seen_q) begin
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WRITE: begin
                gap_d   = GAP_LOAD;
                state_d = S_GAP;
            end

            S_LAUNCH: begin
                state_d = S_DONE;
            end

            S_DONE: begin
                if (restart) begin
                    clr_s   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state logic
    // ------------------------------------------------------------------
    // FIFO pointers, last flag, word counter and presented word
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_seen_d  = last_seen_q;
        words_sent_d = words_sent_q;
        next_instr_d = next_instr_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            next_instr_d = head_word_s;
        end else begin
            rd_ptr_d     = rd_ptr_q;
            next_instr_d = next_instr_q;
        end

        if (clr_s) begin
            last_seen_d  = 1'b0;
            words_sent_d = {CNT_W{1'b0}};
        end else begin
            if (push_s && host.in_last) begin
                last_seen_d = 1'b1;
            end else begin
                last_seen_d = last_seen_q;
            end
            // Counted at the pop edge so the count is visible alongside the
            // mem_write pulse it describes.
            if (pop_s && (words_sent_q != CNT_ALL1)) begin
                words_sent_d = words_sent_q + CNT_ONE;
            end else begin
                words_sent_d = words_sent_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // FSM state, gap counter, FIFO pointers and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gap_q        <= {GW{1'b0}};
            wr_ptr_q     <= {(AW+1){1'b0}};
            rd_ptr_q     <= {(AW+1){1'b0}};
            last_seen_q  <= 1'b0;
            words_sent_q <= {CNT_W{1'b0}};
            next_instr_q <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_seen_q  <= last_seen_d;
            words_sent_q <= words_sent_d;
            next_instr_q <= next_instr_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= host.in_word;
        end
    end

    // Strobes registered from the next state so they line up with the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_write_q <= 1'b0;
            start_q     <= 1'b0;
            cpu_rst_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            mem_write_q <= (state_d == S_WRITE);
            start_q     <= (state_d == S_LAUNCH);
            cpu_rst_q   <= (state_d == S_LAUNCH);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
        end
    end

    assign next_instruction = next_instr_q;
    assign mem_write        = mem_write_q;
    assign start            = start_q;
    assign cpu_rst          = cpu_rst_q;
    assign busy             = busy_q;
    assign words_sent       = words_sent_q;

    // ------------------------------------------------------------------
    // Optional running checksum
    // ------------------------------------------------------------------
`ifdef INSTR_LOADER_CHECKSUM_EN
    function automatic logic [31:0] chk_accumulate(input logic [31:0] acc,
                                                   input logic [31:0] word);
        chk_accumulate = acc ^ word;
    endfunction

    logic [31:0] checksum_q, checksum_d;

    // Checksum folds in the word at its pop, visible during its WRITE cycle
    always_comb begin
        checksum_d = checksum_q;
        if (clr_s) begin
            checksum_d = 32'h0000_0000;
        end else if (pop_s) begin
            checksum_d = chk_accumulate(checksum_q, head_word_s);
        end else begin
            checksum_d = checksum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= 32'h0000_0000;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int DEPTH = 8;
    localparam int GAP   = 3;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             restart = 1'b0;
    logic [31:0]      next_instruction;
    logic             mem_write;
    logic             start;
    logic             cpu_rst;
    logic             busy;
    logic [CNT_W-1:0] words_sent;
    logic [31:0]      checksum;

    instr_loader_if bus ();

    instr_loader #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .host             (bus),
        .restart          (restart),
        .next_instruction (next_instruction),
        .mem_write        (mem_write),
        .start            (start),
        .cpu_rst          (cpu_rst),
        .busy             (busy),
        .words_sent       (words_sent),
        .checksum         (checksum)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errors  = 0;
    int          cyc     = 0;
    int          n_acc   = 0;
    logic [31:0] exp_q [$];
    int          pulse_cyc_q [$];
    int          start_cyc_q [$];

    always @(posedge clk) cyc++;

    // Scoreboard: every mem_write pulse must carry the oldest accepted word
    always @(negedge clk) begin
        logic [31:0] exp_w;
        if (!rst && mem_write) begin
            pulse_cyc_q.push_back(cyc);
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_underflow: mem_write with next_instruction=%h, no word expected", next_instruction);
            end else begin
                exp_w = exp_q.pop_front();
                if (next_instruction !== exp_w) begin
                    errors++;
                    $display("FAIL sb_word: next_instruction=%h expected %h", next_instruction, exp_w);
                end
            end
        end
        if (!rst && start) start_cyc_q.push_back(cyc);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_track();
        pulse_cyc_q.delete();
        start_cyc_q.delete();
        n_acc = 0;
    endtask

    // Offer one word until accepted; optionally check in_ready against occupancy
    task automatic push_word(input logic [31:0] w, input logic last, input bit chk_full,
                             output int waits);
        logic exp_rdy;
        waits = 0;
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        bus.in_last  = last;
        while (1) begin
            if (chk_full) begin
                exp_rdy = ((n_acc - pulse_cyc_q.size()) < DEPTH);
                vectors++;
                if (bus.in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL full_ready: in_ready=%b expected %b (occupancy %0d)",
                             bus.in_ready, exp_rdy, n_acc - pulse_cyc_q.size());
                end
            end
            if (bus.in_ready === 1'b1) begin
                exp_q.push_back(w);
                n_acc++;
                step();
                break;
            end
            waits++;
            if (waits > 200) begin
                vectors++;
                errors++;
                $display("FAIL push_timeout: word %h not accepted after %0d cycles, expected acceptance", w, waits);
                step();
                break;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        while (start_cyc_q.size() == 0 && n < 500) begin
            step();
            n++;
        end
        vectors++;
        if (start_cyc_q.size() == 0) begin
            errors++;
            $display("FAIL %s_launch_timeout: start seen %0d times, expected 1", name, start_cyc_q.size());
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    // Single word with in_last, checked through launch and into DONE
    task automatic run_single(input logic [31:0] w, input string name);
        int waits;
        clear_track();
        push_word(w, 1'b1, 1'b0, waits);
        wait_launch(name);
        vectors++;
        if (pulse_cyc_q.size() !== 1) begin
            errors++;
            $display("FAIL %s_pulses: got %0d mem_write pulses expected 1", name, pulse_cyc_q.size());
        end
        if (pulse_cyc_q.size() > 0 && start_cyc_q.size() > 0) begin
            vectors++;
            if (start_cyc_q[0] - pulse_cyc_q[0] !== GAP + 1) begin
                errors++;
                $display("FAIL %s_launch_delay: got %0d cycles expected %0d", name,
                         start_cyc_q[0] - pulse_cyc_q[0], GAP + 1);
            end
            vectors++;
            if (cpu_rst !== 1'b1) begin
                errors++;
                $display("FAIL %s_cpu_rst: cpu_rst=%b with start, expected 1", name, cpu_rst);
            end
        end
        step();
        vectors++;
        if ({start, cpu_rst, busy, bus.in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_done: start,cpu_rst,busy,in_ready=%b expected 0000", name,
                     {start, cpu_rst, busy, bus.in_ready});
        end
        vectors++;
        if (words_sent !== 8'd1 || next_instruction !== w) begin
            errors++;
            $display("FAIL %s_final: words_sent=%0d next_instruction=%h expected 1 %h", name,
                     words_sent, next_instruction, w);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_word  = 32'h0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        step();
        step();
        vectors++;
        if ({next_instruction, mem_write, start, cpu_rst, busy, words_sent, checksum, bus.in_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ni=%h mw=%b st=%b cr=%b busy=%b ws=%0d cs=%h rdy=%b expected all 0",
                     next_instruction, mem_write, start, cpu_rst, busy, words_sent, checksum, bus.in_ready);
        end
        rst = 1'b0;
        step();
        vectors++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_single_word();
        run_single(32'h00020820, "single");
    endtask

    task automatic test_restart();
        do_restart();
        vectors++;
        if (words_sent !== 8'd0 || bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL restart: words_sent=%0d in_ready=%b busy=%b expected 0 1 0",
                     words_sent, bus.in_ready, busy);
        end
        vectors++;
        if (next_instruction !== 32'h00020820 || checksum !== 32'h0) begin
            errors++;
            $display("FAIL restart_hold: next_instruction=%h checksum=%h expected 00020820 00000000",
                     next_instruction, checksum);
        end
    endtask

    // Six words back to back; a restart pulse during GAP must be ignored
    task automatic test_back_to_back();
        logic [31:0] words [6];
        logic [31:0] exp_cs;
        int waits;
        int n;
        words = '{32'h00020820, 32'h00844022, 32'h00a62824, 32'h00e83025, 32'h0109382a, 32'hac0a0004};
        exp_cs = 32'h0;
        clear_track();
        for (int i = 0; i < 6; i++) begin
            push_word(words[i], (i == 5), 1'b0, waits);
            exp_cs = exp_cs ^ words[i];
            vectors++;
            if (waits !== 0) begin
                errors++;
                $display("FAIL b2b_ready: word %0d waited %0d cycles expected 0", i, waits);
            end
        end
        n = 0;
        while (pulse_cyc_q.size() < 2 && n < 100) begin
            step();
            n++;
        end
        step();
        do_restart();
        wait_launch("b2b");
        vectors++;
        if (pulse_cyc_q.size() !== 6) begin
            errors++;
            $display("FAIL b2b_pulses: got %0d pulses expected 6", pulse_cyc_q.size());
        end else begin
            for (int i = 1; i < 6; i++) begin
                vectors++;
                if (pulse_cyc_q[i] - pulse_cyc_q[i-1] !== GAP + 1) begin
                    errors++;
                    $display("FAIL b2b_spacing: pulse %0d spacing %0d expected %0d", i,
                             pulse_cyc_q[i] - pulse_cyc_q[i-1], GAP + 1);
                end
            end
            if (start_cyc_q.size() > 0) begin
                vectors++;
                if (start_cyc_q[0] - pulse_cyc_q[5] !== GAP + 1) begin
                    errors++;
                    $display("FAIL b2b_launch_delay: got %0d expected %0d",
                             start_cyc_q[0] - pulse_cyc_q[5], GAP + 1);
                end
            end
        end
        step();
`ifndef INSTR_LOADER_CHECKSUM_EN
        exp_cs = 32'h0;
`endif
        vectors++;
        if (words_sent !== 8'd6 || checksum !== exp_cs || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_final: words_sent=%0d checksum=%h pending=%0d expected 6 %h 0",
                     words_sent, checksum, exp_q.size(), exp_cs);
        end
    endtask

    task automatic test_checksum();
        logic [31:0] exp_cs;
        int waits;
        do_restart();
        clear_track();
        push_word(32'h00020820, 1'b0, 1'b0, waits);
        push_word(32'h00844022, 1'b1, 1'b0, waits);
        wait_launch("cksum");
        step();
`ifdef INSTR_LOADER_CHECKSUM_EN
        exp_cs = 32'h00864802;
`else
        exp_cs = 32'h00000000;
`endif
        vectors++;
        if (checksum !== exp_cs || words_sent !== 8'd2) begin
            errors++;
            $display("FAIL cksum: checksum=%h words_sent=%0d expected %h 2", checksum, words_sent, exp_cs);
        end
    endtask

    // Push faster than the drain rate so the FIFO fills up
    task automatic test_fifo_full();
        int waits;
        int total_waits = 0;
        do_restart();
        clear_track();
        for (int i = 0; i < 13; i++) begin
            push_word(32'h1000_0000 + 32'(i * 17), (i == 12), 1'b1, waits);
            total_waits += waits;
        end
        vectors++;
        if (total_waits == 0) begin
            errors++;
            $display("FAIL full_stall: in_ready never dropped, got %0d stall cycles expected >0", total_waits);
        end
        wait_launch("full");
        step();
        vectors++;
        if (words_sent !== 8'd13 || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL full_final: words_sent=%0d pending=%0d expected 13 0", words_sent, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int waits;
        int n = 0;
        do_restart();
        clear_track();
        for (int i = 0; i < 3; i++) push_word(32'hA5A5_0000 + 32'(i), 1'b0, 1'b0, waits);
        while (pulse_cyc_q.size() < 2 && n < 100) begin
            step();
            n++;
        end
        step();
        vectors++;
        if (busy !== 1'b1 || mem_write !== 1'b0 || words_sent !== 8'd2) begin
            errors++;
            $display("FAIL midrst_pre: busy=%b mem_write=%b words_sent=%0d expected 1 0 2",
                     busy, mem_write, words_sent);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({next_instruction, mem_write, start, cpu_rst, busy, words_sent, checksum, bus.in_ready} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: ni=%h mw=%b st=%b cr=%b busy=%b ws=%0d cs=%h rdy=%b expected all 0",
                     next_instruction, mem_write, start, cpu_rst, busy, words_sent, checksum, bus.in_ready);
        end
        step();
        rst = 1'b0;
        exp_q.delete();
        step();
        run_single(32'h00020820, "midrst_single");
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_restart();
        test_back_to_back();
        test_checksum();
        test_fifo_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
